// File: rtl/risc16_prog_loader_pkg.sv
// Shared definitions for the RiSC16 program loader: FSM encoding and stream header layout.
package risc16_prog_loader_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    HDR_HI  = 4'd1,
    HDR_LO  = 4'd2,
    DATA_HI = 4'd3,
    DATA_LO = 4'd4,
    WRITE   = 4'd5,
    RELEASE = 4'd6,
    DONE    = 4'd7,
    ERROR   = 4'd8
  } state_e;

  localparam int HDR_BYTES = 2;
  localparam int HDR_BITS  = 8 * HDR_BYTES;

  // A load is legal only if it carries at least one word and fits in program memory.
  function automatic logic hdr_ok(input logic [HDR_BITS-1:0] n, input int unsigned size);
    return (n != '0) && (32'(n) <= size);
  endfunction

endpackage

// File: rtl/risc16_prog_loader_if.sv
// Byte-stream input and program-memory write port between a host and the loader.
interface risc16_prog_loader_if #(
  parameter int WORD_LENGTH = 16
);
  logic                   start;
  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic                   byte_ready;
  logic                   pen;
  logic [WORD_LENGTH-1:0] addr;
  logic [WORD_LENGTH-1:0] instr;
  logic                   sys_rst;
  logic                   busy;
  logic                   done;
  logic                   error;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, pen, addr, instr, sys_rst, busy, done, error
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, pen, addr, instr, sys_rst, busy, done, error
  );
endinterface

// File: rtl/risc16_prog_loader.sv
// Loads a length-prefixed big-endian word stream into RiSC16 program memory,
// holding the system in reset until the load completes.
//
// state   | meaning
// IDLE    | after reset; system running, waiting for start
// HDR_HI  | waiting for word-count high byte
// HDR_LO  | waiting for word-count low byte, then range check
// DATA_HI | waiting for instruction high byte
// DATA_LO | waiting for instruction low byte
// WRITE   | one-cycle program-memory write of addr/instr
// RELEASE | pen low, system still in reset for RST_CYCLES cycles
// DONE    | load complete; system released
// ERROR   | header rejected; system held in reset
module risc16_prog_loader
  import risc16_prog_loader_pkg::*;
#(
  parameter int WORD_LENGTH  = 16,
  parameter int PROGRAM_SIZE = 20,
  parameter int RST_CYCLES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  risc16_prog_loader_if.slave  bus
);

  localparam int unsigned      PSIZE    = PROGRAM_SIZE;
  localparam logic [15:0]      REL_LOAD = 16'(RST_CYCLES - 1);

  state_e                 state_q;
  logic [7:0]             hdr_hi_q;
  logic [7:0]             data_hi_q;
  logic [HDR_BITS-1:0]    words_q;
  logic [WORD_LENGTH-1:0] idx_q;
  logic [15:0]            rel_q;
  logic                   pen_q;
  logic [WORD_LENGTH-1:0] addr_q;
  logic [WORD_LENGTH-1:0] instr_q;
  logic                   sys_rst_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;
  logic                   byte_ready_q;

  logic                   xfer;
  logic [HDR_BITS-1:0]    hdr_n;

  assign xfer  = bus.byte_valid && byte_ready_q;
  assign hdr_n = {hdr_hi_q, bus.byte_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hdr_hi_q     <= '0;
      data_hi_q    <= '0;
      words_q      <= '0;
      idx_q        <= '0;
      rel_q        <= '0;
      pen_q        <= 1'b0;
      addr_q       <= '0;
      instr_q      <= '0;
      sys_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      byte_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (state_q == IDLE) sys_rst_q <= 1'b0;
          if (bus.start) begin
            state_q      <= HDR_HI;
            addr_q       <= '0;
            idx_q        <= '0;
            sys_rst_q    <= 1'b1;
            pen_q        <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b1;
            byte_ready_q <= 1'b1;
          end
        end
        HDR_HI: begin
          if (xfer) begin
            hdr_hi_q <= bus.byte_in;
            state_q  <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            if (hdr_ok(hdr_n, PSIZE)) begin
              words_q <= hdr_n;
              pen_q   <= 1'b1;
              state_q <= DATA_HI;
            end else begin
              error_q      <= 1'b1;
              busy_q       <= 1'b0;
              byte_ready_q <= 1'b0;
              state_q      <= ERROR;
            end
          end
        end
        DATA_HI: begin
          if (xfer) begin
            data_hi_q <= bus.byte_in;
            state_q   <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (xfer) begin
            // addr follows the word index but only moves together with instr
            instr_q      <= WORD_LENGTH'({data_hi_q, bus.byte_in});
            addr_q       <= idx_q;
            byte_ready_q <= 1'b0;
            state_q      <= WRITE;
          end
        end
        WRITE: begin
          if (words_q == HDR_BITS'(1)) begin
            pen_q   <= 1'b0;
            rel_q   <= REL_LOAD;
            state_q <= RELEASE;
          end else begin
            words_q      <= words_q - HDR_BITS'(1);
            idx_q        <= idx_q + WORD_LENGTH'(1);
            byte_ready_q <= 1'b1;
            state_q      <= DATA_HI;
          end
        end
        RELEASE: begin
          if (rel_q == '0) begin
            sys_rst_q <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end else begin
            rel_q <= rel_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.pen        = pen_q;
  assign bus.addr       = addr_q;
  assign bus.instr      = instr_q;
  assign bus.sys_rst    = sys_rst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_risc16_prog_loader.sv
// Directed self-checking bench for risc16_prog_loader.
module tb_risc16_prog_loader;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  risc16_prog_loader_if #(.WORD_LENGTH(16)) bus();

  risc16_prog_loader #(
    .WORD_LENGTH(16),
    .PROGRAM_SIZE(20),
    .RST_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          wr_cnt;
  logic [15:0] wr_addr  [32];
  logic [15:0] wr_instr [32];
  logic        pen_seen;
  logic        pen_no_rst;

  bq_t basic_s;

  // write cycles are the only cycles with pen high and byte_ready low
  always @(negedge clk) begin
    if (bus.pen) pen_seen = 1'b1;
    if (bus.pen && !bus.sys_rst) pen_no_rst = 1'b1;
    if (bus.pen && !bus.byte_ready) begin
      if (wr_cnt < 32) begin
        wr_addr[wr_cnt]  = bus.addr;
        wr_instr[wr_cnt] = bus.instr;
      end
      wr_cnt++;
    end
  end

  function automatic logic [37:0] outs();
    return {bus.pen, bus.sys_rst, bus.busy, bus.byte_ready, bus.done, bus.error,
            bus.addr, bus.instr};
  endfunction

  task automatic clear_log();
    wr_cnt     = 0;
    pen_seen   = 1'b0;
    pen_no_rst = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic [37:0] snap;
    int k;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      @(posedge clk); #1;
      snap = outs();
      for (int g = 1; g < gap; g++) begin
        @(posedge clk); #1;
        n_cmp++;
        if (outs() !== snap) begin
          n_bad++;
          $display("FAIL gap_hold: outputs %h required %h", outs(), snap);
        end
      end
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.byte_ready) break;
    end
    n_cmp++;
    if (k == 200) begin
      n_bad++;
      $display("FAIL byte_timeout: byte_ready stayed %b, required 1", bus.byte_ready);
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic run_stream(input bq_t s, input int gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (outs() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}) begin
      n_bad++;
      $display("FAIL reset_outs: got %h required pen0 sysrst1 others 0", outs());
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.sys_rst, bus.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_sysrst: sys_rst/busy %b required 00", {bus.sys_rst, bus.busy});
    end
  endtask

  task automatic test_basic();
    clear_log();
    start_pulse();
    n_cmp++;
    if ({bus.busy, bus.byte_ready, bus.sys_rst, bus.done, bus.error, bus.pen} !== 6'b111000
        || bus.addr !== 16'h0000) begin
      n_bad++;
      $display("FAIL start_outs: busy/rdy/sysrst/done/err/pen %b addr %h required 111000 0000",
               {bus.busy, bus.byte_ready, bus.sys_rst, bus.done, bus.error, bus.pen}, bus.addr);
    end
    run_stream(basic_s, 0);
    n_cmp++;
    if ({bus.pen, bus.sys_rst} !== 2'b11) begin
      n_bad++;
      $display("FAIL last_write: pen/sys_rst %b required 11", {bus.pen, bus.sys_rst});
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.pen, bus.sys_rst, bus.busy, bus.done} !== 4'b0110) begin
        n_bad++;
        $display("FAIL release_%0d: pen/sysrst/busy/done %b required 0110", c,
                 {bus.pen, bus.sys_rst, bus.busy, bus.done});
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.pen, bus.sys_rst, bus.busy, bus.done, bus.error} !== 5'b00010) begin
      n_bad++;
      $display("FAIL done_outs: pen/sysrst/busy/done/err %b required 00010",
               {bus.pen, bus.sys_rst, bus.busy, bus.done, bus.error});
    end
    n_cmp++;
    if (wr_cnt !== 3 || wr_addr[0] !== 16'h0000 || wr_instr[0] !== 16'h6A00 ||
        wr_addr[1] !== 16'h0001 || wr_instr[1] !== 16'h6D00 ||
        wr_addr[2] !== 16'h0002 || wr_instr[2] !== 16'h0903 || pen_no_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_writes: cnt %0d (%h,%h) (%h,%h) (%h,%h) pen_no_rst %b required 3 (0,6a00) (1,6d00) (2,0903) 0",
               wr_cnt, wr_addr[0], wr_instr[0], wr_addr[1], wr_instr[1],
               wr_addr[2], wr_instr[2], pen_no_rst);
    end
  endtask

  task automatic test_zero_hdr();
    clear_log();
    start_pulse();
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_clear: done %b required 0", bus.done);
    end
    run_stream('{8'h00, 8'h00}, 0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.error, bus.byte_ready, bus.busy, bus.sys_rst, bus.pen, pen_seen} !== 6'b100100) begin
      n_bad++;
      $display("FAIL zero_hdr: err/rdy/busy/sysrst/pen/pen_seen %b required 100100",
               {bus.error, bus.byte_ready, bus.busy, bus.sys_rst, bus.pen, pen_seen});
    end
  endtask

  task automatic test_oversize();
    clear_log();
    start_pulse();
    n_cmp++;
    if (bus.error !== 1'b0) begin
      n_bad++;
      $display("FAIL error_clear: error %b required 0", bus.error);
    end
    run_stream('{8'h00, 8'h15}, 0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.error, bus.done, bus.sys_rst, pen_seen} !== 4'b1010 || wr_cnt !== 0) begin
      n_bad++;
      $display("FAIL oversize: err/done/sysrst/pen_seen %b writes %0d required 1010 0",
               {bus.error, bus.done, bus.sys_rst, pen_seen}, wr_cnt);
    end
  endtask

  task automatic test_full();
    int k;
    int bad_words;
    clear_log();
    start_pulse();
    run_stream('{8'h00, 8'h14}, 0);
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(i), 0);
      send_byte(8'(i + 8'h40), 0);
    end
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.done) break;
    end
    n_cmp++;
    if ({bus.done, bus.error, bus.sys_rst} !== 3'b100 || wr_cnt !== 20) begin
      n_bad++;
      $display("FAIL full_done: done/err/sysrst %b writes %0d required 100 20",
               {bus.done, bus.error, bus.sys_rst}, wr_cnt);
    end
    bad_words = 0;
    for (int i = 0; i < 20; i++)
      if (wr_addr[i] !== 16'(i) || wr_instr[i] !== {8'(i), 8'(i + 8'h40)}) bad_words++;
    n_cmp++;
    if (bad_words != 0) begin
      n_bad++;
      $display("FAIL full_words: %0d bad words, required 0", bad_words);
    end
    n_cmp++;
    if (wr_addr[19] !== 16'h0013 || wr_instr[19] !== 16'h1353) begin
      n_bad++;
      $display("FAIL full_last: (%h,%h) required (0013,1353)", wr_addr[19], wr_instr[19]);
    end
  endtask

  task automatic test_gaps();
    clear_log();
    start_pulse();
    run_stream(basic_s, 5);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_cnt !== 3 || wr_addr[0] !== 16'h0000 || wr_instr[0] !== 16'h6A00 ||
        wr_addr[1] !== 16'h0001 || wr_instr[1] !== 16'h6D00 ||
        wr_addr[2] !== 16'h0002 || wr_instr[2] !== 16'h0903 ||
        bus.done !== 1'b1 || bus.sys_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL gap_writes: cnt %0d (%h,%h) (%h,%h) (%h,%h) done %b sysrst %b required 3 (0,6a00) (1,6d00) (2,0903) 1 0",
               wr_cnt, wr_addr[0], wr_instr[0], wr_addr[1], wr_instr[1],
               wr_addr[2], wr_instr[2], bus.done, bus.sys_rst);
    end
  endtask

  task automatic test_rst_mid();
    clear_log();
    start_pulse();
    run_stream('{8'h00, 8'h03, 8'h6A, 8'h00, 8'h6D, 8'h00}, 0);
    @(posedge clk); #1;
    n_cmp++;
    if (wr_cnt !== 2) begin
      n_bad++;
      $display("FAIL pre_abort_writes: %0d required 2", wr_cnt);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (outs() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}) begin
      n_bad++;
      $display("FAIL abort_outs: got %h required pen0 sysrst1 others 0", outs());
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.sys_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: sys_rst %b required 0", bus.sys_rst);
    end
    clear_log();
    start_pulse();
    run_stream(basic_s, 0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_cnt !== 3 || wr_addr[2] !== 16'h0002 || wr_instr[2] !== 16'h0903 ||
        wr_addr[0] !== 16'h0000 || wr_instr[0] !== 16'h6A00 || bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL reload: cnt %0d first (%h,%h) last (%h,%h) done %b required 3 (0,6a00) (2,0903) 1",
               wr_cnt, wr_addr[0], wr_instr[0], wr_addr[2], wr_instr[2], bus.done);
    end
  endtask

  task automatic test_start_overlap();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_log();
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b1;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.byte_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL overlap_start: busy/rdy %b required 11", {bus.busy, bus.byte_ready});
    end
    run_stream('{8'h00, 8'h03, 8'h6A, 8'h00, 8'h6D, 8'h00, 8'h09}, 0);
    start_pulse();
    n_cmp++;
    if ({bus.busy, bus.pen, bus.sys_rst, bus.byte_ready} !== 4'b1111 || bus.addr !== 16'h0001) begin
      n_bad++;
      $display("FAIL midload_start: busy/pen/sysrst/rdy %b addr %h required 1111 0001",
               {bus.busy, bus.pen, bus.sys_rst, bus.byte_ready}, bus.addr);
    end
    send_byte(8'h03, 0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_cnt !== 3 || wr_addr[0] !== 16'h0000 || wr_instr[0] !== 16'h6A00 ||
        wr_addr[1] !== 16'h0001 || wr_instr[1] !== 16'h6D00 ||
        wr_addr[2] !== 16'h0002 || wr_instr[2] !== 16'h0903 || bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL overlap_writes: cnt %0d (%h,%h) (%h,%h) (%h,%h) done %b required 3 (0,6a00) (1,6d00) (2,0903) 1",
               wr_cnt, wr_addr[0], wr_instr[0], wr_addr[1], wr_instr[1],
               wr_addr[2], wr_instr[2], bus.done);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    basic_s = '{8'h00, 8'h03, 8'h6A, 8'h00, 8'h6D, 8'h00, 8'h09, 8'h03};
    test_reset();
    test_basic();
    test_zero_hdr();
    test_oversize();
    test_full();
    test_gaps();
    test_rst_mid();
    test_start_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
